aes_arbiter: RTL and testbench

AES_ARBITER -- requirements
Module: aes_arbiter

---
 rtl/aes_arb_pkg.sv | 20 ++
 rtl/aes_arbiter_rr.sv | 39 +++
 rtl/aes_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_aes_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types and widths for the AES core arbiter.
package aes_arb_pkg;

  localparam int KEY_W = 128;
  localparam int BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_LD   = 3'd1,
    KEY_WAIT = 3'd2,
    TXT_LD   = 3'd3,
    TXT_WAIT = 3'd4,
    RSP      = 3'd5
  } arb_state_e;

  function automatic logic is_wait_state(input arb_state_e s);
    return (s == KEY_WAIT) || (s == TXT_WAIT);
  endfunction

endpackage

// File: rtl/aes_arbiter_rr.sv
// Round-robin grant: the first requesting index at or above the pointer wins,
// otherwise the lowest requesting index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  // Two-pass priority search: indices >= pointer first, then wrap to the bottom
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[i] && (i >= int'(i_ptr))) begin
        o_valid    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = PW'(i);
      end else begin
        o_valid = o_valid;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[i]) begin
        o_valid    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = PW'(i);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one AES core among NREQ requesters, one request in flight at a time,
// skipping key expansion when the requested key is already loaded in the core.
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*KEY_W-1:0] req_key,
  input  logic [NREQ*BLK_W-1:0] req_text,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [BLK_W-1:0]      rsp_text,
  output logic                  rsp_err,
  output logic                  core_kld,
  output logic [KEY_W-1:0]      core_key,
  input  logic                  core_kdone,
  output logic                  core_ld,
  output logic [BLK_W-1:0]      core_text_in,
  input  logic                  core_done,
  input  logic [BLK_W-1:0]      core_text_out
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_idx;
  logic [KEY_W-1:0] r_key;
  logic [BLK_W-1:0] r_text;
  logic [KEY_W-1:0] r_cached_key;
  logic             r_key_cached;
  logic [CW-1:0]    r_cnt;
  logic [BLK_W-1:0] r_rsp_text;
  logic             r_rsp_err;
  logic [NREQ-1:0]  r_rsp_valid;
  logic             r_core_kld;
  logic             r_core_ld;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_win_idx;
  logic             w_any;
  logic [KEY_W-1:0] w_win_key;
  logic [BLK_W-1:0] w_win_text;
  logic             w_accept;
  logic             w_hit;
  logic             w_timeout;
  logic             w_rsp_ack;
  logic [NREQ-1:0]  w_idx_oh;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_valid (w_any)
  );

  // Mux the winner's key/text and decode the in-flight requester's handshake
  always_comb begin
    w_win_key  = '0;
    w_win_text = '0;
    w_rsp_ack  = 1'b0;
    w_idx_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_idx == PW'(i)) begin
        w_win_key  = req_key[i*KEY_W +: KEY_W];
        w_win_text = req_text[i*BLK_W +: BLK_W];
      end else begin
        w_win_key = w_win_key;
      end
      if (r_idx == PW'(i)) begin
        w_rsp_ack   = rsp_ready[i];
        w_idx_oh[i] = 1'b1;
      end else begin
        w_rsp_ack = w_rsp_ack;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_hit     = r_key_cached && (w_win_key == r_cached_key);
    w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept = 1'b1;
          w_next   = w_hit ? TXT_LD : KEY_LD;
        end else begin
          w_next = IDLE;
        end
      end
      KEY_LD: w_next = KEY_WAIT;
      KEY_WAIT: begin
        if (core_kdone) begin
          w_next = TXT_LD;
        end else if (w_timeout) begin
          w_next = RSP;
        end else begin
          w_next = KEY_WAIT;
        end
      end
      TXT_LD: w_next = TXT_WAIT;
      TXT_WAIT: begin
        if (core_done || w_timeout) begin
          w_next = RSP;
        end else begin
          w_next = TXT_WAIT;
        end
      end
      RSP: begin
        if (w_rsp_ack) begin
          w_next = IDLE;
        end else begin
          w_next = RSP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Grant is only visible in the accept cycle, never while reset is applied
  always_comb begin
    if (w_accept && !rst) begin
      req_ready = w_grant;
    end else begin
      req_ready = '0;
    end
  end

  // State, request latch, key cache, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_key        <= '0;
      r_text       <= '0;
      r_cached_key <= '0;
      r_key_cached <= 1'b0;
      r_cnt        <= '0;
      r_rsp_text   <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= '0;
      r_core_kld   <= 1'b0;
      r_core_ld    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_core_kld <= (w_next == KEY_LD);
      r_core_ld  <= (w_next == TXT_LD);
      r_rsp_valid <= (w_next == RSP) ? w_idx_oh : '0;

      if (w_accept) begin
        r_key  <= w_win_key;
        r_text <= w_win_text;
        r_idx  <= w_win_idx;
        r_ptr  <= (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
      end

      // Counter runs only while staying in a wait state; any transition clears it
      if (is_wait_state(r_state) && (w_next == r_state)) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end

      if ((r_state == KEY_WAIT) && core_kdone) begin
        r_cached_key <= r_key;
        r_key_cached <= 1'b1;
      end

      if ((r_state == TXT_WAIT) && core_done) begin
        r_rsp_text <= core_text_out;
        r_rsp_err  <= 1'b0;
      end else if (is_wait_state(r_state) && (w_next == RSP)) begin
        // Core state is unknown after a timeout, so force a key reload next time
        r_rsp_text   <= '0;
        r_rsp_err    <= 1'b1;
        r_key_cached <= 1'b0;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_text     = r_rsp_text;
  assign rsp_err      = r_rsp_err;
  assign core_kld     = r_core_kld;
  assign core_ld      = r_core_ld;
  assign core_key     = r_key;
  assign core_text_in = r_text;

endmodule

// File: tb/tb_aes_arbiter.sv
// Bench for aes_arbiter: behavioural AES-core stand-in plus a reference model of
// round-robin order and key-cache hits.
module tb_aes_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_key;
  logic [255:0] req_text;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_text;
  logic         rsp_err;
  logic         core_kld;
  logic [127:0] core_key;
  logic         core_kdone;
  logic         core_ld;
  logic [127:0] core_text_in;
  logic         core_done;
  logic [127:0] core_text_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // core stand-in state
  int kdelay = 2, ddelay = 3;
  bit hold_done = 1'b0;
  int kcnt, dcnt, kld_cnt, ld_cnt, ld_cyc;
  logic [127:0] key_m, txt_m;

  // reference model
  int m_ptr = 0;
  bit m_cvalid = 1'b0;
  logic [127:0] m_ckey = '0;

  aes_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_err(rsp_err),
    .core_kld(core_kld), .core_key(core_key), .core_kdone(core_kdone),
    .core_ld(core_ld), .core_text_in(core_text_in), .core_done(core_done),
    .core_text_out(core_text_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && t == P0) return C0;
    return {k[63:0] ^ t[127:64], t[63:0] + k[127:64]} ^ 128'h5a5a_0000_ffff_1234_0f0f_a5a5_3c3c_9999;
  endfunction

  function automatic int model_pick(input logic [1:0] m, input int p);
    if (((m >> p) & 2'b01) != 2'b00) return p;
    if (((m >> (1 - p)) & 2'b01) != 2'b00) return 1 - p;
    return -1;
  endfunction

  // Core stand-in: kdone kdelay cycles after kld, done ddelay cycles after ld
  initial begin
    core_kdone = 1'b0; core_done = 1'b0; core_text_out = '0;
    kcnt = -1; dcnt = -1; kld_cnt = 0; ld_cnt = 0; ld_cyc = 0; key_m = '0; txt_m = '0;
    forever begin
      @(negedge clk);
      core_kdone = 1'b0;
      core_done = 1'b0;
      core_text_out = {$urandom, $urandom, $urandom, $urandom};
      if (rst) begin
        kcnt = -1; dcnt = -1;
      end else begin
        if (core_kld) begin
          kld_cnt++; key_m = core_key; kcnt = kdelay;
        end else if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) begin core_kdone = 1'b1; kcnt = -1; end
        end
        if (core_ld) begin
          ld_cnt++; ld_cyc = cyc; txt_m = core_text_in; dcnt = ddelay;
        end else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            if (!hold_done) begin
              core_done = 1'b1; core_text_out = core_fn(key_m, txt_m);
            end
            dcnt = -1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, cmp=%0d bad=%0d", n_cmp, n_bad);
    $fatal(1);
  end

  // One transaction: raise vmask, wait for grant and response, then handshake.
  task automatic txn(input logic [1:0] vmask, input bit hold, input int stall,
                     output int win, output logic [1:0] rv, output logic [127:0] txt,
                     output logic err, output int nkld, output int nld, output int ldlat,
                     output int rsplat, output bit stable, output bit busy_rdy, output bit tmo);
    int k0, l0, acc_cyc;
    k0 = kld_cnt; l0 = ld_cnt; win = -1; rv = '0; txt = '0; err = 1'b0;
    nkld = 0; nld = 0; ldlat = -1; rsplat = -1; stable = 1'b1; busy_rdy = 1'b0; tmo = 1'b0;
    acc_cyc = 0;
    @(negedge clk); req_valid = vmask; #2;
    for (int i = 0; i < 20 && win < 0; i++) begin
      if (req_ready != 2'b00) begin
        win = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
        acc_cyc = cyc;
      end else begin
        @(negedge clk); #2;
      end
    end
    if (win < 0) begin tmo = 1'b1; req_valid = 2'b00; return; end
    @(negedge clk);
    if (!hold) req_valid = 2'b00;
    for (int i = 0; i < 300 && rv == 2'b00; i++) begin
      #2;
      if (rsp_valid != 2'b00) begin
        rv = rsp_valid; txt = rsp_text; err = rsp_err; rsplat = cyc - acc_cyc;
      end else begin
        busy_rdy |= (req_ready != 2'b00);
        @(negedge clk);
      end
    end
    if (rv == 2'b00) begin tmo = 1'b1; req_valid = 2'b00; return; end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); rsp_ready = ~rv; #2;
      stable &= (rsp_valid == rv) && (rsp_text == txt) && (rsp_err == err);
      busy_rdy |= (req_ready != 2'b00);
    end
    @(negedge clk); rsp_ready = rv; req_valid = 2'b00;
    @(negedge clk); rsp_ready = 2'b00;
    nkld = kld_cnt - k0; nld = ld_cnt - l0; ldlat = ld_cyc - acc_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; req_key = '0; req_text = '0;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, core_kld, core_ld} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_valid, rsp_err, core_kld, core_ld});
    end
    n_cmp++;
    if ({rsp_text, core_key, core_text_in} !== 384'b0) begin
      n_bad++; $display("FAIL reset_data: got rsp_text=%h core_key=%h want 0", rsp_text, core_key);
    end
    @(negedge clk); rst = 1'b0;
    m_ptr = 0; m_cvalid = 1'b0;
  endtask

  task automatic test_fips_miss();
    int w, nk, nl, ll, rl; logic [1:0] rv; logic [127:0] t; logic e; bit st, br, to;
    kdelay = 3; ddelay = 5;
    req_key = {128'h0, K0}; req_text = {128'h0, P0};
    txn(2'b01, 1'b0, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
    n_cmp++; if (to || w !== 0) begin n_bad++; $display("FAIL fips_win: got %0d tmo=%0d want 0", w, to); end
    n_cmp++; if (t !== C0) begin n_bad++; $display("FAIL fips_text: got %h want %h", t, C0); end
    n_cmp++; if (e !== 1'b0 || rv !== 2'b01) begin n_bad++; $display("FAIL fips_rsp: got err=%b rv=%b want 0/01", e, rv); end
    n_cmp++; if (nk !== 1 || nl !== 1) begin n_bad++; $display("FAIL fips_pulses: got kld=%0d ld=%0d want 1/1", nk, nl); end
    n_cmp++; if (ll !== 2 + kdelay) begin n_bad++; $display("FAIL fips_ld_lat: got %0d want %0d", ll, 2 + kdelay); end
    m_ptr = 1; m_cvalid = 1'b1; m_ckey = K0;
  endtask

  task automatic test_key_hit();
    int w, nk, nl, ll, rl; logic [1:0] rv; logic [127:0] t, tx; logic e; bit st, br, to;
    tx = {$urandom, $urandom, $urandom, $urandom};
    req_key = {K0, 128'h0}; req_text = {tx, 128'h0};
    txn(2'b10, 1'b0, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
    n_cmp++; if (to || w !== 1 || rv !== 2'b10) begin n_bad++; $display("FAIL hit_win: got %0d rv=%b want 1", w, rv); end
    n_cmp++; if (nk !== 0) begin n_bad++; $display("FAIL hit_no_kld: got %0d want 0", nk); end
    n_cmp++; if (ll !== 1) begin n_bad++; $display("FAIL hit_ld_lat: got %0d want 1", ll); end
    n_cmp++; if (t !== core_fn(K0, tx)) begin n_bad++; $display("FAIL hit_text: got %h want %h", t, core_fn(K0, tx)); end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int w, nk, nl, ll, rl, ew; logic [1:0] rv; logic [127:0] t; logic e; bit st, br, to;
    for (int i = 0; i < 4; i++) begin
      req_key = {K0, K0}; req_text = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ew = model_pick(2'b11, m_ptr);
      txn(2'b11, 1'b1, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
      n_cmp++; if (to || w !== ew || w !== (i % 2)) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, w, i % 2); end
      n_cmp++; if (br) begin n_bad++; $display("FAIL rr_busy_ready[%0d]: got req_ready while busy want none", i); end
      m_ptr = (ew + 1) % 2;
    end
  endtask

  task automatic test_timeout();
    int w, nk, nl, ll, rl; logic [1:0] rv; logic [127:0] t; logic e; bit st, br, to;
    req_key = {K0, K0}; req_text = {P0, P0};
    hold_done = 1'b1;
    txn(2'b01, 1'b0, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
    hold_done = 1'b0;
    n_cmp++; if (to || e !== 1'b1 || t !== 128'h0) begin n_bad++; $display("FAIL tmo_rsp: got err=%b text=%h want 1/0", e, t); end
    n_cmp++; if (rl !== 2 + TIMEOUT) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", rl, 2 + TIMEOUT); end
    m_ptr = 1; m_cvalid = 1'b0;
    txn(2'b01, 1'b0, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
    n_cmp++; if (to || nk !== 1 || t !== C0) begin n_bad++; $display("FAIL tmo_reload: got kld=%0d text=%h want 1/%h", nk, t, C0); end
    m_ptr = 1; m_cvalid = 1'b1; m_ckey = K0;
  endtask

  task automatic test_stall();
    int w, nk, nl, ll, rl, ew; logic [1:0] rv; logic [127:0] t, ta, tb; logic e; bit st, br, to;
    ta = {$urandom, $urandom, $urandom, $urandom}; tb = {$urandom, $urandom, $urandom, $urandom};
    req_key = {K0, K0}; req_text = {tb, ta};
    ew = model_pick(2'b11, m_ptr);
    txn(2'b11, 1'b1, 10, w, rv, t, e, nk, nl, ll, rl, st, br, to);
    n_cmp++; if (to || w !== ew) begin n_bad++; $display("FAIL stall_win: got %0d want %0d", w, ew); end
    n_cmp++; if (!st) begin n_bad++; $display("FAIL stall_stable: got unstable response want stable"); end
    n_cmp++; if (br) begin n_bad++; $display("FAIL stall_ready: got req_ready during stall want none"); end
    n_cmp++; if (t !== core_fn(K0, (ew == 0) ? ta : tb)) begin n_bad++; $display("FAIL stall_text: got %h", t); end
    m_ptr = (ew + 1) % 2;
  endtask

  task automatic test_reset_midop();
    int l0, w, nk, nl, ll, rl; logic [1:0] rv; logic [127:0] t; logic e; bit st, br, to, seen;
    req_key = {K0, K0}; req_text = {P0, P0};
    hold_done = 1'b1; l0 = ld_cnt;
    @(negedge clk); req_valid = 2'b01;
    for (int i = 0; i < 50 && ld_cnt == l0; i++) @(negedge clk);
    n_cmp++; if (ld_cnt == l0) begin n_bad++; $display("FAIL midop_ld: got no core_ld want one"); end
    repeat (2) @(negedge clk);
    rst = 1'b1; req_valid = 2'b00;
    @(negedge clk); #2;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, core_kld, core_ld, rsp_text, core_key, core_text_in} !== 391'b0) begin
      n_bad++; $display("FAIL midop_outputs: got ctrl=%b key=%h want 0", {req_ready, rsp_valid, rsp_err, core_kld, core_ld}, core_key);
    end
    rst = 1'b0; hold_done = 1'b0; seen = 1'b0;
    repeat (10) begin @(negedge clk); #2; seen |= (rsp_valid != 2'b00); end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL midop_abandon: got response want none"); end
    m_ptr = 0; m_cvalid = 1'b0;
    txn(2'b01, 1'b0, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
    n_cmp++; if (to || nk !== 1 || t !== C0) begin n_bad++; $display("FAIL midop_reload: got kld=%0d text=%h want 1/%h", nk, t, C0); end
    m_ptr = 1; m_cvalid = 1'b1; m_ckey = K0;
  endtask

  task automatic test_random();
    int w, nk, nl, ll, rl, ew; logic [1:0] rv, vm; logic [127:0] t, ek, et; logic e; bit st, br, to, hit;
    logic [127:0] pool [3];
    logic [127:0] ka, kb, ta, tb;
    pool[0] = K0; pool[1] = {$urandom, $urandom, $urandom, $urandom}; pool[2] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 12; i++) begin
      vm = 2'($urandom_range(1, 3));
      kdelay = $urandom_range(1, 4); ddelay = $urandom_range(1, 6);
      ka = pool[$urandom_range(0, 2)]; kb = pool[$urandom_range(0, 2)];
      ta = {$urandom, $urandom, $urandom, $urandom}; tb = {$urandom, $urandom, $urandom, $urandom};
      req_key = {kb, ka}; req_text = {tb, ta};
      ew = model_pick(vm, m_ptr);
      ek = (ew == 0) ? ka : kb; et = (ew == 0) ? ta : tb;
      hit = m_cvalid && (ek == m_ckey);
      txn(vm, 1'b0, 0, w, rv, t, e, nk, nl, ll, rl, st, br, to);
      n_cmp++; if (to || w !== ew || rv !== (2'b01 << ew)) begin n_bad++; $display("FAIL rand_win[%0d]: got %0d rv=%b want %0d", i, w, rv, ew); end
      n_cmp++; if (t !== core_fn(ek, et) || e !== 1'b0) begin n_bad++; $display("FAIL rand_text[%0d]: got %h err=%b want %h", i, t, e, core_fn(ek, et)); end
      n_cmp++; if (nk !== (hit ? 0 : 1) || nl !== 1) begin n_bad++; $display("FAIL rand_pulses[%0d]: got kld=%0d ld=%0d hit=%0d", i, nk, nl, hit); end
      n_cmp++; if (ll !== (hit ? 1 : 2 + kdelay)) begin n_bad++; $display("FAIL rand_ld_lat[%0d]: got %0d want %0d", i, ll, hit ? 1 : 2 + kdelay); end
      m_ptr = (ew + 1) % 2; m_cvalid = 1'b1; m_ckey = ek;
    end
  endtask

  initial begin
    test_reset();
    test_fips_miss();
    test_key_hit();
    test_round_robin();
    test_timeout();
    test_stall();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
